// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: RAM / I/O page / unmapped decode with programmable wait
// states, one-cycle ready pulse, and a small register page (SEG, STATUS, free-running counter).
module mem_bus_responder #(
  parameter int          RAM_DEPTH   = 2048,
  parameter logic [15:0] IO_BASE     = 16'h6000,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [7:0]  UNMAPPED_RD = 8'hEA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ready,
  output logic [7:0]  seg_value,
  output logic        bus_err
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [7:0]    mem [RAM_DEPTH];
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_q_reg;

  logic          we_reg;
  logic [15:0]   addr_reg;
  logic [7:0]    wdata_reg;
  logic          is_ram_reg;
  logic          unmapped_reg;
  logic [7:0]    io_rd_reg;
  logic [7:0]    rdata_hold_reg;
  logic [3:0]    wait_cnt_reg;
  logic [15:0]   counter_reg;
  logic [7:0]    hi_snap_reg;
  logic          err_sticky_reg;
  logic          ready_reg;
  logic          bus_err_reg;
  logic [7:0]    seg_reg;

  logic          addr_is_ram;
  logic          addr_is_io;
  logic          addr_unmapped;
  logic [7:0]    io_rd_now;
  logic [7:0]    resp_data;
  logic          commit_io;

  assign addr_is_ram   = ({16'd0, addr} < 32'(RAM_DEPTH));
  assign addr_is_io    = (addr[15:4] == IO_BASE[15:4]);
  assign addr_unmapped = !addr_is_ram && !(addr_is_io && (addr[3:0] < 4'd4));

  // Register-page reads are snapshotted at accept; only one transaction is ever in flight.
  always_comb begin
    io_rd_now = UNMAPPED_RD;
    if (addr_is_io) begin
      case (addr[3:0])
        4'd0:    io_rd_now = seg_reg;
        4'd1:    io_rd_now = {7'd0, err_sticky_reg};
        4'd2:    io_rd_now = counter_reg[7:0];
        4'd3:    io_rd_now = hi_snap_reg;
        default: io_rd_now = UNMAPPED_RD;
      endcase
    end
  end

  // Read address follows the live bus in IDLE so a zero-wait read has data in RESP.
  assign ram_addr  = (state == IDLE) ? addr[AW-1:0] : addr_reg[AW-1:0];
  assign resp_data = is_ram_reg ? ram_q_reg : io_rd_reg;
  assign commit_io = (state == RESP) && we_reg && !is_ram_reg && !unmapped_reg;

  always_ff @(posedge clk) begin
    if (state == RESP && we_reg && is_ram_reg)
      mem[addr_reg[AW-1:0]] <= wdata_reg;
    ram_q_reg <= mem[ram_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      counter_reg <= 16'd0;
    else if (commit_io && addr_reg[3:0] == 4'd2)
      counter_reg <= 16'd0;
    else
      counter_reg <= counter_reg + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      we_reg         <= 1'b0;
      addr_reg       <= 16'd0;
      wdata_reg      <= 8'd0;
      is_ram_reg     <= 1'b0;
      unmapped_reg   <= 1'b0;
      io_rd_reg      <= 8'd0;
      rdata_hold_reg <= 8'd0;
      wait_cnt_reg   <= 4'd0;
      hi_snap_reg    <= 8'd0;
      err_sticky_reg <= 1'b0;
      ready_reg      <= 1'b0;
      bus_err_reg    <= 1'b0;
      seg_reg        <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_reg       <= we;
            addr_reg     <= addr;
            wdata_reg    <= wdata;
            is_ram_reg   <= addr_is_ram;
            unmapped_reg <= addr_unmapped;
            io_rd_reg    <= io_rd_now;
            if (!we && addr_is_io && addr[3:0] == 4'd2)
              hi_snap_reg <= counter_reg[15:8];
            if (WAIT_CYCLES > 0) begin
              state        <= WAIT;
              wait_cnt_reg <= WAIT_LAST;
            end else begin
              state       <= RESP;
              ready_reg   <= 1'b1;
              bus_err_reg <= addr_unmapped;
            end
          end
        end
        WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state       <= RESP;
            ready_reg   <= 1'b1;
            bus_err_reg <= unmapped_reg;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        RESP: begin
          state          <= IDLE;
          ready_reg      <= 1'b0;
          bus_err_reg    <= 1'b0;
          rdata_hold_reg <= resp_data;
          if (unmapped_reg)
            err_sticky_reg <= 1'b1;
          if (commit_io) begin
            if (addr_reg[3:0] == 4'd0)
              seg_reg <= wdata_reg;
            else if (addr_reg[3:0] == 4'd1 && wdata_reg[0])
              err_sticky_reg <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rdata     = ready_reg ? resp_data : rdata_hold_reg;
  assign ready     = ready_reg;
  assign bus_err   = bus_err_reg;
  assign seg_value = seg_reg;
endmodule
